// File: rtl/ref_frame_fetch.sv
// ref_frame_fetch: streams the reference luma frame band by band (line fastest) with edge-clamped rows
module ref_frame_fetch #(
  parameter int WORDS_PER_LINE = 480,
  parameter int FRAME_LINES    = 2160,
  parameter int BANDS          = 270,
  parameter int LINES_PER_BAND = 24,
  parameter int BAND_STEP      = 8,
  parameter int MARGIN         = 8,
  parameter int ADDR_W         = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic              in_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_rdata,
  output logic [63:0]       data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              frame_end
);
  localparam int LW = LINES_PER_BAND > 1 ? $clog2(LINES_PER_BAND) : 1;
  localparam int CW = WORDS_PER_LINE > 1 ? $clog2(WORDS_PER_LINE) : 1;
  localparam int BW = BANDS > 1 ? $clog2(BANDS) : 1;
  localparam int INIT_LINE = -MARGIN;
  localparam int INIT_ROW = (INIT_LINE < 0 ? 0 : INIT_LINE > FRAME_LINES-1 ? FRAME_LINES-1 : INIT_LINE) * WORDS_PER_LINE;
  localparam logic [LW-1:0] L_LAST = LW'(LINES_PER_BAND-1);
  localparam logic [LW-1:0] L_SNAP = LW'(BAND_STEP-1);
  localparam logic [CW-1:0] C_LAST = CW'(WORDS_PER_LINE-1);
  localparam logic [BW-1:0] B_LAST = BW'(BANDS-1);
  localparam logic signed [23:0] TOP = 24'(FRAME_LINES-1);
  localparam logic signed [23:0] INIT_L = 24'(INIT_LINE);
  localparam logic [ADDR_W-1:0] INIT_R = ADDR_W'(INIT_ROW);
  localparam logic [ADDR_W-1:0] WPL = ADDR_W'(WORDS_PER_LINE);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state;
  logic [LW-1:0] l;
  logic [CW-1:0] col;
  logic [BW-1:0] band;
  logic [ADDR_W-1:0] base, cur_row, start_row, nxt_row, inc_row;
  logic signed [23:0] cur_line, start_line, nxt_line, inc_line;
  logic [63:0] hold;
  logic last, step_row;

  assign last = l == L_LAST && col == C_LAST && band == B_LAST;
  assign step_row = !cur_line[23] && cur_line < TOP;
  assign inc_line = cur_line + 24'sd1;
  assign inc_row = cur_row + (step_row ? WPL : '0);
  assign data_out = data_valid ? mem_rdata : hold;

  // Rows move only while the line is inside the frame; the next band's first row is
  // snapshotted when l passes BAND_STEP, so no multiply is needed on band advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      l <= '0;
      col <= '0;
      band <= '0;
      base <= '0;
      cur_line <= INIT_L;
      start_line <= INIT_L;
      nxt_line <= INIT_L;
      cur_row <= INIT_R;
      start_row <= INIT_R;
      nxt_row <= INIT_R;
      mem_rd_en <= 1'b0;
      mem_addr <= '0;
      data_valid <= 1'b0;
      hold <= '0;
      busy <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      data_valid <= mem_rd_en;
      frame_end <= 1'b0;
      if (data_valid) hold <= mem_rdata;
      case (state)
        IDLE: if (start && !frame_end) begin
          state <= FETCH;
          busy <= 1'b1;
          base <= frame_base;
          l <= '0;
          col <= '0;
          band <= '0;
          cur_line <= INIT_L;
          start_line <= INIT_L;
          cur_row <= INIT_R;
          start_row <= INIT_R;
        end
        FETCH: if (in_en) begin
          mem_rd_en <= 1'b1;
          mem_addr <= base + cur_row + ADDR_W'(col);
          if (last) state <= DRAIN;
          if (l == L_LAST) begin
            l <= '0;
            cur_line <= col == C_LAST ? nxt_line : start_line;
            cur_row <= col == C_LAST ? nxt_row : start_row;
            if (col == C_LAST) begin
              col <= '0;
              band <= band + BW'(1);
              start_line <= nxt_line;
              start_row <= nxt_row;
            end else col <= col + CW'(1);
          end else begin
            l <= l + LW'(1);
            cur_line <= inc_line;
            cur_row <= inc_row;
            if (l == L_SNAP) begin
              nxt_line <= inc_line;
              nxt_row <= inc_row;
            end
          end
        end
        DRAIN: if (!mem_rd_en) begin
          frame_end <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ref_frame_fetch.sv
// tb_ref_frame_fetch: directed checks of fetch order, latency, stalls, base wrap, start filtering and reset abort
module tb_ref_frame_fetch;
  logic clk = 0, reset = 1, start = 0, in_en = 0;
  logic [20:0] frame_base = '0;
  logic mem_rd_en, data_valid, busy, frame_end;
  logic [20:0] mem_addr;
  logic [63:0] mem_rdata = '0, data_out;
  int vec = 0, miss = 0;
  int cyc = 0, fe_cnt = 0, fe_cyc = -1, last_dv_cyc = -1, tail = 0, max_tail = 0;
  logic fe_busy = 1'b1;
  logic [20:0] addr_q[$];
  logic [63:0] dat_q[$];

  ref_frame_fetch #(.WORDS_PER_LINE(4), .FRAME_LINES(6), .BANDS(3), .LINES_PER_BAND(4),
    .BAND_STEP(2), .MARGIN(1), .ADDR_W(21)) dut (
    .clk(clk), .reset(reset), .start(start), .frame_base(frame_base), .in_en(in_en),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .data_out(data_out),
    .data_valid(data_valid), .busy(busy), .frame_end(frame_end));

  always #5 clk = ~clk;

  function automatic logic [63:0] word(input logic [20:0] a);
    return {43'h5A5A5A5A5A, a};
  endfunction

  function automatic logic [20:0] exp_addr(input logic [20:0] b, input int i);
    int line;
    line = (i / 16) * 2 + (i % 4) - 1;
    if (line < 0) line = 0;
    if (line > 5) line = 5;
    return b + 21'(line * 4 + (i / 4) % 4);
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_rdata <= word(mem_addr);

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) addr_q.push_back(mem_addr);
    if (data_valid) begin
      dat_q.push_back(data_out);
      last_dv_cyc <= cyc;
    end
    if (frame_end) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
      fe_busy <= busy;
    end
    if (in_en) tail <= 0;
    else if (data_valid) begin
      tail <= tail + 1;
      if (tail + 1 > max_tail) max_tail <= tail + 1;
    end
  end

  // mode 0: in_en high, 1: in_en pattern 1,0,0,1, 2: start held high throughout
  task automatic run(input logic [20:0] b, input int mode, output bit done);
    done = 0;
    frame_base = b;
    start = 1;
    @(posedge clk); #1;
    start = (mode == 2);
    if (mode == 2) frame_base = 21'd100;
    for (int k = 0; k < 1000; k++) begin
      in_en = (mode != 1) || (k % 4 == 0) || (k % 4 == 3);
      @(posedge clk); #1;
      if (frame_end) begin done = 1; break; end
    end
    @(posedge clk); #1;
    start = 0;
    in_en = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (mem_rd_en !== 0) begin miss++; $display("FAIL reset_rd_en got %b want 0", mem_rd_en); end
    vec++; if (mem_addr !== 0) begin miss++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
    vec++; if (data_valid !== 0) begin miss++; $display("FAIL reset_valid got %b want 0", data_valid); end
    vec++; if (data_out !== 0) begin miss++; $display("FAIL reset_data got %h want 0", data_out); end
    vec++; if (busy !== 0) begin miss++; $display("FAIL reset_busy got %b want 0", busy); end
    vec++; if (frame_end !== 0) begin miss++; $display("FAIL reset_frame_end got %b want 0", frame_end); end
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int f0;
    bit done;
    logic [20:0] first8[8];
    logic [20:0] last4[4];
    first8 = '{21'd0, 21'd0, 21'd4, 21'd8, 21'd1, 21'd1, 21'd5, 21'd9};
    last4 = '{21'd15, 21'd19, 21'd23, 21'd23};
    addr_q.delete(); dat_q.delete();
    f0 = fe_cnt;
    run(21'd0, 0, done);
    repeat (3) @(posedge clk);
    #1;
    vec++; if (done !== 1) begin miss++; $display("FAIL basic_timeout got %b want 1", done); end
    vec++; if (addr_q.size() != 48) begin miss++; $display("FAIL basic_reads got %0d want 48", addr_q.size()); end
    vec++; if (dat_q.size() != 48) begin miss++; $display("FAIL basic_valids got %0d want 48", dat_q.size()); end
    for (int i = 0; i < 8 && i < addr_q.size(); i++) begin
      vec++; if (addr_q[i] !== first8[i]) begin miss++; $display("FAIL basic_first[%0d] got %0d want %0d", i, addr_q[i], first8[i]); end
    end
    for (int i = 0; i < 4 && addr_q.size() == 48; i++) begin
      vec++; if (addr_q[44+i] !== last4[i]) begin miss++; $display("FAIL basic_last[%0d] got %0d want %0d", i, addr_q[44+i], last4[i]); end
    end
    for (int i = 0; i < dat_q.size() && i < 48; i++) begin
      vec++; if (dat_q[i] !== word(exp_addr(21'd0, i))) begin miss++; $display("FAIL basic_data[%0d] got %h want %h", i, dat_q[i], word(exp_addr(21'd0, i))); end
    end
    vec++; if (fe_cnt - f0 != 1) begin miss++; $display("FAIL basic_frame_ends got %0d want 1", fe_cnt - f0); end
    vec++; if (fe_cyc != last_dv_cyc + 1) begin miss++; $display("FAIL basic_fe_timing got %0d want %0d", fe_cyc, last_dv_cyc + 1); end
    vec++; if (fe_busy !== 0) begin miss++; $display("FAIL basic_busy_at_fe got %b want 0", fe_busy); end
  endtask

  task automatic test_latency;
    int n;
    frame_base = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (mem_rd_en !== 0) begin miss++; $display("FAIL lat_idle_rd got %b want 0", mem_rd_en); end
    vec++; if (busy !== 1) begin miss++; $display("FAIL lat_busy got %b want 1", busy); end
    in_en = 1;
    @(negedge clk);
    vec++; if (mem_rd_en !== 0) begin miss++; $display("FAIL lat_rd_early got %b want 0", mem_rd_en); end
    @(negedge clk);
    vec++; if (mem_rd_en !== 1 || data_valid !== 0) begin miss++; $display("FAIL lat_rd got rd=%b dv=%b want rd=1 dv=0", mem_rd_en, data_valid); end
    vec++; if (mem_addr !== 0) begin miss++; $display("FAIL lat_addr got %0d want 0", mem_addr); end
    @(negedge clk);
    vec++; if (data_valid !== 1) begin miss++; $display("FAIL lat_valid got %b want 1", data_valid); end
    vec++; if (data_out !== word(21'd0)) begin miss++; $display("FAIL lat_data got %h want %h", data_out, word(21'd0)); end
    @(posedge clk); #1;
    in_en = 0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (data_valid) n++;
    end
    vec++; if (n != 2) begin miss++; $display("FAIL lat_tail got %0d want 2", n); end
    vec++; if (data_out !== word(exp_addr(21'd0, 2))) begin miss++; $display("FAIL lat_hold got %h want %h", data_out, word(exp_addr(21'd0, 2))); end
    in_en = 1;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (frame_end) begin n = 1; break; end
    end
    in_en = 0;
    vec++; if (n != 1) begin miss++; $display("FAIL lat_frame_end got %0d want 1", n); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_stall;
    bit done;
    addr_q.delete(); dat_q.delete();
    run(21'd0, 1, done);
    repeat (3) @(posedge clk);
    #1;
    vec++; if (done !== 1) begin miss++; $display("FAIL stall_timeout got %b want 1", done); end
    vec++; if (addr_q.size() != 48) begin miss++; $display("FAIL stall_reads got %0d want 48", addr_q.size()); end
    for (int i = 0; i < addr_q.size() && i < 48; i++) begin
      vec++; if (addr_q[i] !== exp_addr(21'd0, i)) begin miss++; $display("FAIL stall_addr[%0d] got %0d want %0d", i, addr_q[i], exp_addr(21'd0, i)); end
    end
    vec++; if (dat_q.size() != 48) begin miss++; $display("FAIL stall_valids got %0d want 48", dat_q.size()); end
    vec++; if (max_tail > 2) begin miss++; $display("FAIL stall_tail got %0d want <=2", max_tail); end
  endtask

  task automatic test_base_wrap;
    bit done;
    logic [20:0] first4[4];
    first4 = '{21'h1FFFFE, 21'h1FFFFE, 21'd2, 21'd6};
    addr_q.delete(); dat_q.delete();
    run(21'h1FFFFE, 0, done);
    repeat (3) @(posedge clk);
    #1;
    vec++; if (done !== 1) begin miss++; $display("FAIL wrap_timeout got %b want 1", done); end
    vec++; if (addr_q.size() != 48) begin miss++; $display("FAIL wrap_reads got %0d want 48", addr_q.size()); end
    for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
      vec++; if (addr_q[i] !== first4[i]) begin miss++; $display("FAIL wrap_first[%0d] got %h want %h", i, addr_q[i], first4[i]); end
    end
    for (int i = 0; i < dat_q.size() && i < 48; i++) begin
      vec++; if (dat_q[i] !== word(exp_addr(21'h1FFFFE, i))) begin miss++; $display("FAIL wrap_data[%0d] got %h want %h", i, dat_q[i], word(exp_addr(21'h1FFFFE, i))); end
    end
  endtask

  task automatic test_start_busy;
    int f0;
    bit done;
    addr_q.delete(); dat_q.delete();
    f0 = fe_cnt;
    run(21'd0, 2, done);
    repeat (5) @(posedge clk);
    #1;
    vec++; if (done !== 1) begin miss++; $display("FAIL busy_timeout got %b want 1", done); end
    vec++; if (busy !== 0) begin miss++; $display("FAIL busy_restart got %b want 0", busy); end
    vec++; if (fe_cnt - f0 != 1) begin miss++; $display("FAIL busy_frame_ends got %0d want 1", fe_cnt - f0); end
    vec++; if (addr_q.size() != 48) begin miss++; $display("FAIL busy_reads got %0d want 48", addr_q.size()); end
    for (int i = 0; i < addr_q.size() && i < 48; i++) begin
      vec++; if (addr_q[i] !== exp_addr(21'd0, i)) begin miss++; $display("FAIL busy_addr[%0d] got %0d want %0d", i, addr_q[i], exp_addr(21'd0, i)); end
    end
    addr_q.delete(); dat_q.delete();
    run(21'd0, 0, done);
    repeat (3) @(posedge clk);
    #1;
    vec++; if (dat_q.size() != 48) begin miss++; $display("FAIL second_valids got %0d want 48", dat_q.size()); end
    vec++; if (fe_cnt - f0 != 2) begin miss++; $display("FAIL second_frame_ends got %0d want 2", fe_cnt - f0); end
  endtask

  task automatic test_reset_mid;
    int f0, s;
    bit done;
    addr_q.delete(); dat_q.delete();
    f0 = fe_cnt;
    frame_base = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    in_en = 1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (dat_q.size() >= 20) break;
    end
    vec++; if (dat_q.size() != 20) begin miss++; $display("FAIL rmid_words got %0d want 20", dat_q.size()); end
    reset = 1;
    #1;
    vec++; if (mem_rd_en !== 0 || data_valid !== 0) begin miss++; $display("FAIL rmid_strobes got rd=%b dv=%b want 0", mem_rd_en, data_valid); end
    vec++; if (mem_addr !== 0 || data_out !== 0) begin miss++; $display("FAIL rmid_buses got addr=%0d data=%h want 0", mem_addr, data_out); end
    vec++; if (busy !== 0 || frame_end !== 0) begin miss++; $display("FAIL rmid_status got busy=%b fe=%b want 0", busy, frame_end); end
    s = dat_q.size();
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    in_en = 0;
    repeat (4) @(posedge clk);
    #1;
    vec++; if (dat_q.size() != s) begin miss++; $display("FAIL rmid_flight got %0d want %0d", dat_q.size(), s); end
    vec++; if (fe_cnt != f0) begin miss++; $display("FAIL rmid_frame_end got %0d want %0d", fe_cnt, f0); end
    addr_q.delete(); dat_q.delete();
    run(21'd0, 0, done);
    repeat (3) @(posedge clk);
    #1;
    vec++; if (addr_q.size() != 48) begin miss++; $display("FAIL replay_reads got %0d want 48", addr_q.size()); end
    for (int i = 0; i < addr_q.size() && i < 48; i++) begin
      vec++; if (addr_q[i] !== exp_addr(21'd0, i)) begin miss++; $display("FAIL replay_addr[%0d] got %0d want %0d", i, addr_q[i], exp_addr(21'd0, i)); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_latency;
    test_stall;
    test_base_wrap;
    test_start_busy;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
